latch_bank_wr_sched: RTL
========================

// Module: latch_bank_wr_sched
// PURPOSE
//  Write scheduler for a shared bank of 2**AW level-sensitive D latches, each DW bits wide.
//  NREQ requesters compete for the bank; a round-robin arbiter picks one.
//  A 4-phase FSM then drives glitch-free, registered latch enables with setup and hold
//  margins around the enable pulse. Sits between requesters and the latch bank, which
//  takes lat_d and lat_en[i] directly.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  DW    8  data width per latch entry
//  AW    2  entry address width; bank depth = 2**AW
// PORTS
//  clk       in   1         system clock, rising edge
//  rst_n     in   1         asynchronous active-low reset
//  req       in   NREQ      request per requester; held with addr/data until its ack
//  req_addr  in   NREQ*AW   packed entry address; requester i uses bits [i*AW +: AW]
//  req_data  in   NREQ*DW   packed write data; requester i uses bits [i*DW +: DW]
//  gnt       out  NREQ      one-hot grant; high for the winner from SETUP through HOLD
//  ack       out  NREQ      one-cycle completion pulse to the winner, in HOLD
//  lat_en    out  2**AW     one-hot latch enables; high only in OPEN
//  lat_d     out  DW        latch data; stable from SETUP through HOLD
//  busy      out  1         high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, rr_ptr=0, and gnt, ack, lat_en, lat_d, busy all 0, immediately.
//   - The open-latch enable drops without waiting for a clock edge; no ack is issued.
//   - Latch contents are not touched. An interrupted requester still sees req high
//     after reset and is re-arbitrated from rr_ptr=0.
//  Outputs: all registered; no combinational path from req to any output.
//  FSM: IDLE -> SETUP -> OPEN -> HOLD -> IDLE, one cycle per state.
//   - IDLE: if |req, the arbiter searches from rr_ptr upward, wrapping modulo NREQ.
//     The first set bit wins. Winner index, addr and data are captured. Go to SETUP.
//     If no request is pending, stay in IDLE.
//   - SETUP: gnt[w]=1, lat_d=data, lat_en=0.
//   - OPEN: lat_en[addr]=1, so exactly one bit is high. gnt and lat_d are held.
//   - HOLD: lat_en=0, lat_d held, ack[w]=1. rr_ptr <= (w+1) mod NREQ.
//  Latency and throughput:
//   - Request sampled at edge k: SETUP in cycle k+1, OPEN in k+2, HOLD/ack in k+3.
//   - Peak rate is one write per 4 cycles. No back-to-back overlap: IDLE always
//     separates transactions.
//  Boundary conditions:
//   - Capture is final. Changes to req, addr or data after the IDLE edge are ignored.
//     If a requester drops req mid-transaction, the write still completes and ack
//     still pulses.
//   - If the winner holds req high through ack, it is a new request. It competes in
//     the next IDLE with its priority now last.
//   - rr_ptr wraps from NREQ-1 to 0. With all requesters pending, the grant order is
//     0,1,..,NREQ-1,0.
//   - Writes from different requesters to the same addr are serialized in grant order;
//     the last write wins.
//   - Invariants at all times: gnt is one-hot or zero, ack is one-hot or zero,
//     lat_en is one-hot or zero.
// TESTING
//  1. Reset, then req=0001, addr0=2, data0=A5:
//     lat_en=0100 in cycle k+2 only, lat_d=A5 for k+1..k+3, ack[0] in k+3.
//  2. Hold req=1111 for 16 cycles: grants in order 0,1,2,3,0,...;
//     each ack exactly 4 cycles after the previous one; lat_en never multi-hot.
//  3. After requester 2 is granted, req=0101: requester 0 is granted next
//     (rr_ptr=3 wraps to 0), then requester 2.
//  4. Change data0 to 3C in SETUP: lat_d stays A5 through HOLD; a bench latch model
//     at addr 2 reads A5.
//  5. Drive rst_n=0 mid-cycle during OPEN: lat_en=0 and gnt=0 immediately, no ack,
//     busy=0; after release, the pending req restarts at rr_ptr=0.
//  6. Requester 1 drops req in OPEN: ack[1] still pulses in HOLD, then FSM returns to
//     IDLE and busy=0.

Source files
------------

// File: rtl/latch_bank_wr_sched.sv
// Write scheduler for a bank of level-sensitive latches: round-robin arbitration
// followed by a registered SETUP/OPEN/HOLD enable sequence with setup and hold margins.
module latch_bank_wr_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [2**AW-1:0]     lat_en,
  output logic [DW-1:0]        lat_d,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     rr_ptr, rr_next;
  logic [PW-1:0]     win, win_next;
  logic [AW-1:0]     cap_addr, addr_next;
  logic [NREQ-1:0]   gnt_next, ack_next;
  logic [2**AW-1:0]  lat_en_next;
  logic [DW-1:0]     lat_d_next;
  logic              busy_next;
  logic              found;
  logic [PW-1:0]     pick;
  logic [PW:0]       idx;

  // Rotating search starting at rr_ptr, wrapping modulo NREQ; first pending wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // Outputs are computed for the next state and registered, so nothing reaches
  // a port combinationally from req.
  always_comb begin
    state_next  = state;
    rr_next     = rr_ptr;
    win_next    = win;
    addr_next   = cap_addr;
    lat_d_next  = lat_d;
    gnt_next    = gnt;
    ack_next    = '0;
    lat_en_next = '0;
    case (state)
      IDLE: begin
        gnt_next = '0;
        if (found) begin
          state_next     = SETUP;
          win_next       = pick;
          addr_next      = req_addr[pick*AW +: AW];
          lat_d_next     = req_data[pick*DW +: DW];
          gnt_next[pick] = 1'b1;
        end
      end
      SETUP: begin
        state_next            = OPEN;
        lat_en_next[cap_addr] = 1'b1;
      end
      OPEN: begin
        state_next    = HOLD;
        ack_next[win] = 1'b1;
        rr_next       = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
      end
      HOLD: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win      <= '0;
      cap_addr <= '0;
      gnt      <= '0;
      ack      <= '0;
      lat_en   <= '0;
      lat_d    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_next;
      win      <= win_next;
      cap_addr <= addr_next;
      gnt      <= gnt_next;
      ack      <= ack_next;
      lat_en   <= lat_en_next;
      lat_d    <= lat_d_next;
      busy     <= busy_next;
    end
  end

endmodule
